keypad_encoder: RTL and testbench

KEYPAD_ENCODER -- requirements
Module: keypad_encoder

---
 rtl/keypad_encoder.sv | 163 ++++++++++++++++
 tb/tb_keypad_encoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_encoder.sv
// 4x4 matrix keypad scanner: drives one row low at a time, debounces a single
// pressed key, and reports its code on BCD with a one-cycle KeyValid pulse.
module keypad_encoder #(
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 20000
) (
   input  logic       Clk,
   input  logic       nReset,
   input  logic [3:0] Cols,
   output logic [3:0] Rows,
   output logic [3:0] BCD,
   output logic       KeyValid,
   output logic       KeyHeld
);

   // state       | meaning
   // ST_SCAN     | drive current row, sample columns on the last cycle of the row
   // ST_DEBOUNCE | row held, captured column pattern must stay stable
   // ST_EMIT     | one cycle: KeyValid high, BCD/KeyHeld already loaded
   // ST_RELEASE  | row held, wait for columns all-high for DEBOUNCE cycles

   localparam int SW = $clog2(SCAN_DIV);
   localparam int DW = $clog2(DEBOUNCE);

   typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_EMIT, ST_RELEASE} state_t;

   state_t        state, state_nxt;
   logic [3:0]    cols_meta, cols_sync;
   logic [1:0]    row, row_nxt;
   logic [SW-1:0] scan_cnt, scan_cnt_nxt;
   logic [DW-1:0] deb_cnt, deb_cnt_nxt;
   logic [3:0]    cap_cols, cap_cols_nxt;
   logic [3:0]    bcd_nxt;
   logic          held_nxt;
   logic          one_low;

   function automatic logic [1:0] col_of(input logic [3:0] c);
      case (c)
         4'b1110: col_of = 2'd0;
         4'b1101: col_of = 2'd1;
         4'b1011: col_of = 2'd2;
         default: col_of = 2'd3;
      endcase
   endfunction

   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'b00_00: key_code = 4'h1;
         4'b00_01: key_code = 4'h2;
         4'b00_10: key_code = 4'h3;
         4'b00_11: key_code = 4'hA;
         4'b01_00: key_code = 4'h4;
         4'b01_01: key_code = 4'h5;
         4'b01_10: key_code = 4'h6;
         4'b01_11: key_code = 4'hB;
         4'b10_00: key_code = 4'h7;
         4'b10_01: key_code = 4'h8;
         4'b10_10: key_code = 4'h9;
         4'b10_11: key_code = 4'hC;
         4'b11_00: key_code = 4'hE;
         4'b11_01: key_code = 4'h0;
         4'b11_10: key_code = 4'hF;
         default:  key_code = 4'hD;
      endcase
   endfunction

   always_comb begin
      case (cols_sync)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
         default:                            one_low = 1'b0;
      endcase
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         cols_meta <= 4'hF;
         cols_sync <= 4'hF;
      end else begin
         cols_meta <= Cols;
         cols_sync <= cols_meta;
      end
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state    <= ST_SCAN;
         row      <= 2'd0;
         scan_cnt <= SW'(SCAN_DIV - 1);
         deb_cnt  <= '0;
         cap_cols <= 4'hF;
         BCD      <= 4'h0;
         KeyHeld  <= 1'b0;
      end else begin
         state    <= state_nxt;
         row      <= row_nxt;
         scan_cnt <= scan_cnt_nxt;
         deb_cnt  <= deb_cnt_nxt;
         cap_cols <= cap_cols_nxt;
         BCD      <= bcd_nxt;
         KeyHeld  <= held_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      row_nxt      = row;
      scan_cnt_nxt = scan_cnt;
      deb_cnt_nxt  = deb_cnt;
      cap_cols_nxt = cap_cols;
      bcd_nxt      = BCD;
      held_nxt     = KeyHeld;
      case (state)
         ST_SCAN: begin
            if (scan_cnt == '0) begin
               // Sampling only at the end of the row gives the lines time to settle.
               if (one_low) begin
                  cap_cols_nxt = cols_sync;
                  deb_cnt_nxt  = DW'(DEBOUNCE - 1);
                  state_nxt    = ST_DEBOUNCE;
               end else begin
                  row_nxt      = row + 2'd1;
                  scan_cnt_nxt = SW'(SCAN_DIV - 1);
               end
            end else begin
               scan_cnt_nxt = scan_cnt - 1'b1;
            end
         end
         ST_DEBOUNCE: begin
            if (cols_sync != cap_cols) begin
               scan_cnt_nxt = SW'(SCAN_DIV - 1);
               state_nxt    = ST_SCAN;
            end else if (deb_cnt == '0) begin
               bcd_nxt   = key_code(row, col_of(cap_cols));
               held_nxt  = 1'b1;
               state_nxt = ST_EMIT;
            end else begin
               deb_cnt_nxt = deb_cnt - 1'b1;
            end
         end
         ST_EMIT: begin
            deb_cnt_nxt = DW'(DEBOUNCE - 1);
            state_nxt   = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (cols_sync != 4'hF) begin
               deb_cnt_nxt = DW'(DEBOUNCE - 1);
            end else if (deb_cnt == '0) begin
               held_nxt     = 1'b0;
               row_nxt      = row + 2'd1;
               scan_cnt_nxt = SW'(SCAN_DIV - 1);
               state_nxt    = ST_SCAN;
            end else begin
               deb_cnt_nxt = deb_cnt - 1'b1;
            end
         end
         default: state_nxt = ST_SCAN;
      endcase
   end

   assign Rows     = ~(4'b0001 << row);
   assign KeyValid = (state == ST_EMIT);

endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: a keypad model closes switches between Rows and Cols;
// presses are checked for code, latency, single pulse and release timing.
module tb_keypad_encoder;

   localparam int SD      = 4;
   localparam int DB      = 8;
   localparam int LAT_MAX = 2 + SD * 4 + DB + 1;

   logic       clk = 1'b0;
   logic       n_reset = 1'b0;
   logic [3:0] cols, rows, bcd;
   logic       key_valid, key_held;
   logic [15:0] pressed = '0;

   int checks = 0;
   int failures = 0;
   int mon_err = 0;
   logic prev_kv = 1'b0;

   typedef struct {
      int         r;
      int         c;
      logic [3:0] exp;
   } vec_t;
   vec_t tbl[16];

   keypad_encoder #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
      .Clk(clk), .nReset(n_reset), .Cols(cols), .Rows(rows),
      .BCD(bcd), .KeyValid(key_valid), .KeyHeld(key_held)
   );

   always #5 clk = ~clk;

   // Switch matrix: a pressed key pulls its column low while its row is driven low.
   always_comb begin
      cols = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !rows[r]) cols[c] = 1'b0;
   end

   always @(negedge clk) begin
      if (key_valid && prev_kv) mon_err <= mon_err + 1;
      if (!(rows inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) mon_err <= mon_err + 1;
      prev_kv <= key_valid;
   end

   // Key code derived from the printed keypad legend, row-major.
   function automatic logic [3:0] code_of(input int k);
      string s;
      byte   ch;
      s  = "123A456B789CE0FD";
      ch = s[k];
      if (ch >= 8'd65) return 4'(ch - 8'd55);
      return 4'(ch - 8'd48);
   endfunction

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic check_eq(input string name, input int act, input int exp);
      check_range(name, act, exp, exp);
   endtask

   task automatic wait_rows(input logic [3:0] v);
      int n = 0;
      while (rows != v && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_range("wait_rows", n, 0, 99);
   endtask

   task automatic wait_valid(input string name, input int lo, input int hi);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!key_valid && n < 80);
      check_range({name, "_latency"}, n, lo, hi);
   endtask

   task automatic wait_released(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (key_held && n < 60);
      check_range({name, "_release"}, n, DB + 2, DB + 3);
   endtask

   task automatic press_and_check(input int k, input logic [3:0] exp, input string name);
      int extra = 0;
      pressed[k] = 1'b1;
      wait_valid(name, DB + 2, LAT_MAX);
      check_eq({name, "_bcd"}, bcd, exp);
      check_eq({name, "_held"}, key_held, 1);
      repeat (30) begin
         @(negedge clk);
         if (key_valid) extra++;
      end
      check_eq({name, "_extra_pulses"}, extra, 0);
      pressed[k] = 1'b0;
      wait_released(name);
      check_eq({name, "_bcd_hold"}, bcd, exp);
      repeat (5) @(negedge clk);
   endtask

   initial begin
      int pulses;
      int n;
      logic [3:0] seq [4];
      logic [3:0] prev;
      bit bcd_stuck;

      tbl[0]  = '{0, 0, 4'h1}; tbl[1]  = '{0, 1, 4'h2}; tbl[2]  = '{0, 2, 4'h3}; tbl[3]  = '{0, 3, 4'hA};
      tbl[4]  = '{1, 0, 4'h4}; tbl[5]  = '{1, 1, 4'h5}; tbl[6]  = '{1, 2, 4'h6}; tbl[7]  = '{1, 3, 4'hB};
      tbl[8]  = '{2, 0, 4'h7}; tbl[9]  = '{2, 1, 4'h8}; tbl[10] = '{2, 2, 4'h9}; tbl[11] = '{2, 3, 4'hC};
      tbl[12] = '{3, 0, 4'hE}; tbl[13] = '{3, 1, 4'h0}; tbl[14] = '{3, 2, 4'hF}; tbl[15] = '{3, 3, 4'hD};

      repeat (3) @(negedge clk);
      check_eq("reset_rows", rows, 4'b1110);
      check_eq("reset_bcd", bcd, 0);
      check_eq("reset_valid", key_valid, 0);
      check_eq("reset_held", key_held, 0);
      n_reset = 1'b1;

      foreach (tbl[i])
         press_and_check(tbl[i].r * 4 + tbl[i].c, tbl[i].exp, $sformatf("key_r%0dc%0d", tbl[i].r, tbl[i].c));

      // Bouncing contact on key 8 (column 1): no pulse until it settles.
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         pressed[9] = ~pressed[9];
         repeat (3) begin
            @(negedge clk);
            if (key_valid) pulses++;
         end
      end
      check_eq("bounce_no_pulse", pulses, 0);
      press_and_check(9, 4'h8, "bounce_settled");

      // Two columns low on row 0: ignored, scanning continues through every row.
      pressed[0] = 1'b1;
      pressed[1] = 1'b1;
      wait_rows(4'b1110);
      seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;
      pulses = 0;
      prev = rows;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
            if (key_valid) pulses++;
         end while (rows == prev && n < 40);
         check_eq($sformatf("multi_rows_%0d", i), rows, seq[i]);
         prev = rows;
      end
      check_eq("multi_no_pulse", pulses, 0);
      check_eq("multi_not_held", key_held, 0);
      pressed[0] = 1'b0;
      pressed[1] = 1'b0;
      repeat (5) @(negedge clk);

      // Rollover: 5 held, 9 added; only 5 reported until both released.
      pressed[5] = 1'b1;
      wait_valid("roll_5", DB + 2, LAT_MAX);
      check_eq("roll_5_bcd", bcd, 4'h5);
      pressed[10] = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (key_valid) pulses++;
      end
      check_eq("roll_9_ignored", pulses, 0);
      check_eq("roll_bcd_kept", bcd, 4'h5);
      check_eq("roll_held", key_held, 1);
      pressed[5] = 1'b0;
      pressed[10] = 1'b0;
      wait_released("roll_both");
      repeat (5) @(negedge clk);
      press_and_check(10, 4'h9, "roll_9_repress");

      // Reset three cycles into the debounce of key 4.
      wait_rows(4'b1110);
      pressed[4] = 1'b1;
      wait_rows(4'b1101);
      repeat (7) @(negedge clk);
      check_eq("rstdeb_no_pulse_yet", key_valid, 0);
      #2 n_reset = 1'b0;
      #1;
      check_eq("rstdeb_rows", rows, 4'b1110);
      check_eq("rstdeb_bcd", bcd, 0);
      check_eq("rstdeb_valid", key_valid, 0);
      check_eq("rstdeb_held", key_held, 0);
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         if (key_valid) pulses++;
      end
      check_eq("rstdeb_no_pulse_in_reset", pulses, 0);
      n_reset = 1'b1;
      n = 0;
      bcd_stuck = 1'b1;
      do begin
         @(negedge clk);
         n++;
         if (!key_valid && bcd != 4'h0) bcd_stuck = 1'b0;
      end while (!key_valid && n < 80);
      check_range("rstdeb_redetect_latency", n, 2 * SD + DB, 2 * SD + DB + 2);
      check_eq("rstdeb_bcd_zero_until_pulse", bcd_stuck, 1);
      check_eq("rstdeb_bcd_new", bcd, 4'h4);
      pressed[4] = 1'b0;
      wait_released("rstdeb");
      repeat (5) @(negedge clk);

      // Random keys at random scan phases against the legend model.
      for (int i = 0; i < 20; i++) begin
         int k;
         k = int'($urandom_range(0, 15));
         repeat ($urandom_range(0, 4 * SD)) @(negedge clk);
         press_and_check(k, code_of(k), $sformatf("rand%0d_k%0d", i, k));
      end

      repeat (2) @(negedge clk);
      check_eq("monitor_violations", mon_err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
